// File: rtl/wt_if.sv
// Row-load handshake between the upstream weight source and wt_loader.
// One beat carries a full row of `size` weights; element i feeds column i.
interface wt_if #(
    parameter int size      = 16,
    parameter int bit_width = 8
);
    logic                                wt_valid;
    logic                                wt_ready;
    logic [size-1:0][bit_width-1:0]      wt_data;

    modport master (output wt_valid, output wt_data, input  wt_ready);
    modport slave  (input  wt_valid, input  wt_data, output wt_ready);
endinterface

// File: rtl/wt_loader.sv
// Weight-load sequencer feeding row 0 of a weight-stationary array.
// Shifts exactly `size` rows down the column chains, then pulses done.
module wt_loader #(
    parameter int size      = 16,
    parameter int bit_width = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    wt_if.slave                            wt,
    output logic                           control,
    output logic [size-1:0][bit_width-1:0] wt_path_out,
    output logic                           busy,
    output logic                           done
);
    localparam int cnt_w = $clog2(size + 1);

    localparam logic [1:0] st_idle  = 2'd0;
    localparam logic [1:0] st_load  = 2'd1;
    localparam logic [1:0] st_flush = 2'd2;

    logic [1:0]       state;
    logic [cnt_w-1:0] row_cnt;
    logic             accept;
    logic             last_beat;

    assign wt.wt_ready = (state == st_load);
    assign busy        = (state != st_idle);
    assign accept      = wt.wt_valid & wt.wt_ready;
    assign last_beat   = (row_cnt == cnt_w'(size - 1));

    // NOTE: every register below uses <= so all of them see the same pre-edge
    // values of state and row_cnt; blocking writes would chain updates in one edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= st_idle;
            row_cnt     <= '0;
            control     <= 1'b0;
            wt_path_out <= '0;
            done        <= 1'b0;
        end else begin
            // A cycle without an accept is a bubble: array holds, path holds.
            control <= accept;
            done    <= (state == st_flush);
            if (accept) begin
                wt_path_out <= wt.wt_data;
            end

            case (state)
                st_idle: begin
                    if (start) begin
                        state   <= st_load;
                        row_cnt <= '0;
                    end
                end
                st_load: begin
                    if (accept) begin
                        row_cnt <= row_cnt + 1'b1;
                        if (last_beat) begin
                            state <= st_flush;
                        end
                    end
                end
                st_flush: begin
                    state <= st_idle;
                end
                default: begin
                    state <= st_idle;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_wt_loader.sv
// Directed bench for wt_loader at size=4: reset, back-to-back load, bubbles,
// ignored start, mid-load reset and start in the done cycle.
module tb_wt_loader;
    localparam int size      = 4;
    localparam int bit_width = 8;
    localparam int row_w     = size * bit_width;

    typedef logic [size-1:0][bit_width-1:0] row_t;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic control;
    logic busy;
    logic done;
    row_t wt_path_out;

    wt_if #(.size(size), .bit_width(bit_width)) bus ();

    wt_loader #(.size(size), .bit_width(bit_width)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .wt          (bus),
        .control     (control),
        .wt_path_out (wt_path_out),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;

    // Array column model: row 0 takes wt_path_out on each control pulse.
    row_t arr [size];
    always @(posedge clk) begin
        if (control) begin
            for (int r = size - 1; r > 0; r--) arr[r] <= arr[r-1];
            arr[0] <= wt_path_out;
        end
    end

    // Per-cycle pulse counters sampled mid-cycle.
    int pulse_cnt = 0;
    int done_cnt  = 0;
    always @(negedge clk) begin
        if (control === 1'b1) pulse_cnt++;
        if (done === 1'b1)    done_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic row_t row_val(input int k);
        row_t r;
        for (int i = 0; i < size; i++) r[i] = bit_width'(4 * (k - 1) + i + 1);
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_ready", 64'(bus.wt_ready), 64'd1);
        check("start_busy", 64'(busy), 64'd1);
    endtask

    task automatic beat(input int k);
        bus.wt_valid = 1'b1;
        bus.wt_data  = row_val(k);
        step();
        bus.wt_valid = 1'b0;
        check($sformatf("beat%0d_control", k), 64'(control), 64'd1);
        check($sformatf("beat%0d_path", k), 64'(wt_path_out), 64'(row_val(k)));
    endtask

    task automatic finish_load(input string tag, input int p0, input int d0);
        check({tag, "_flush_ready"}, 64'(bus.wt_ready), 64'd0);
        step();
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_done_control"}, 64'(control), 64'd0);
        check({tag, "_done_busy"}, 64'(busy), 64'd0);
        step();
        check({tag, "_done_drop"}, 64'(done), 64'd0);
        check({tag, "_pulses"}, 64'(pulse_cnt - p0), 64'd4);
        check({tag, "_done_cnt"}, 64'(done_cnt - d0), 64'd1);
    endtask

    int p0, d0;

    initial begin
        for (int r = 0; r < size; r++) arr[r] = '0;
        reset        = 1'b1;
        start        = 1'b1;
        bus.wt_valid = 1'b1;
        bus.wt_data  = row_val(7);

        // 1: reset dominates start and wt_valid
        step();
        step();
        check("rst_control", 64'(control), 64'd0);
        check("rst_path", 64'(wt_path_out), 64'd0);
        check("rst_ready", 64'(bus.wt_ready), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        reset        = 1'b0;
        start        = 1'b0;
        bus.wt_valid = 1'b0;
        step();
        check("idle_ready", 64'(bus.wt_ready), 64'd0);

        // 2: back-to-back load
        p0 = pulse_cnt; d0 = done_cnt;
        do_start();
        for (int k = 1; k <= 4; k++) beat(k);
        finish_load("b2b", p0, d0);
        check("arr_row0", 64'(arr[0]), 64'(row_val(4)));
        check("arr_row3", 64'(arr[3]), 64'(row_val(1)));
        check("arr_row1", 64'(arr[1]), 64'(row_val(3)));

        // 3: two bubble cycles after beat 2
        p0 = pulse_cnt; d0 = done_cnt;
        do_start();
        beat(1);
        beat(2);
        for (int b = 0; b < 2; b++) begin
            step();
            check("bubble_control", 64'(control), 64'd0);
            check("bubble_path", 64'(wt_path_out), 64'(row_val(2)));
            check("bubble_ready", 64'(bus.wt_ready), 64'd1);
        end
        beat(3);
        beat(4);
        finish_load("bubble", p0, d0);

        // 4: start during a load is ignored
        p0 = pulse_cnt; d0 = done_cnt;
        do_start();
        beat(1);
        start = 1'b1;
        beat(2);
        start = 1'b0;
        beat(3);
        beat(4);
        finish_load("busy_start", p0, d0);

        // 5: reset after beat 2 aborts, then a fresh load
        d0 = done_cnt;
        do_start();
        beat(1);
        beat(2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_control", 64'(control), 64'd0);
        check("abort_ready", 64'(bus.wt_ready), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        step();
        check("abort_no_done", 64'(done_cnt - d0), 64'd0);
        check("abort_stay_idle", 64'(bus.wt_ready), 64'd0);
        p0 = pulse_cnt; d0 = done_cnt;
        do_start();
        for (int k = 1; k <= 4; k++) beat(k);
        check("reload_flush_ready", 64'(bus.wt_ready), 64'd0);
        step();
        check("reload_done", 64'(done), 64'd1);

        // 6: start in the done cycle is honoured
        start = 1'b1;
        step();
        start = 1'b0;
        check("done_start_ready", 64'(bus.wt_ready), 64'd1);
        check("done_start_done", 64'(done), 64'd0);
        p0 = pulse_cnt; d0 = done_cnt;
        for (int k = 1; k <= 4; k++) beat(k);
        finish_load("second", p0, d0);
        check("second_arr_row0", 64'(arr[0]), 64'(row_val(4)));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
